// File: rtl/pack_dst_gen.sv
// Stream-packer front end: assigns each kept lane a banyan destination from a running fill pointer.
// Optional PACK_DST_GEN_STATS_EN adds accepted-word and accepted-packet counters.
module pack_dst_gen #(
    parameter int N      = 4,
    parameter int DWIDTH = 8,
    parameter int LOGN   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N*DWIDTH-1:0]  s_data,
    input  logic [N-1:0]         s_keep,
    input  logic                 s_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [N*DWIDTH-1:0]  din,
    output logic [N*LOGN-1:0]    dst_in,
    output logic [N-1:0]         in_vld,
    output logic                 beat_full,
    output logic                 flush,
    output logic [LOGN-1:0]      fill_ptr
`ifdef PACK_DST_GEN_STATS_EN
    ,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_pkts
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic [N*DWIDTH-1:0]   r_din;
    logic [N*LOGN-1:0]     r_dst;
    logic [N-1:0]          r_vld;
    logic                  r_full;
    logic                  r_flush;
    logic [LOGN-1:0]       r_fill_ptr;

    logic                  w_accept;
    logic [LOGN:0]         w_run;
    logic [LOGN:0]         w_cnt;
    logic [LOGN:0]         w_sum;
    logic [N*LOGN-1:0]     w_dst;

    assign w_accept = s_valid && r_ready;
    assign w_sum    = {1'b0, r_fill_ptr} + w_cnt;

    // Prefix count of kept lanes gives every lane (kept or not) its destination.
    always_comb begin
        w_run = {(LOGN+1){1'b0}};
        w_dst = {(N*LOGN){1'b0}};
        for (int i = 0; i < N; i++) begin
            w_dst[i*LOGN +: LOGN] = r_fill_ptr + w_run[LOGN-1:0];
            w_run = w_run + {{LOGN{1'b0}}, s_keep[i]};
        end
        w_cnt = w_run;
    end

    // Issue register, fill pointer and RUN/FLUSH control.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_RUN;
            r_ready    <= 1'b0;
            r_din      <= {(N*DWIDTH){1'b0}};
            r_dst      <= {(N*LOGN){1'b0}};
            r_vld      <= {N{1'b0}};
            r_full     <= 1'b0;
            r_flush    <= 1'b0;
            r_fill_ptr <= {LOGN{1'b0}};
        end else begin
            r_vld   <= {N{1'b0}};
            r_full  <= 1'b0;
            r_flush <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_din      <= s_data;
                        r_dst      <= w_dst;
                        r_vld      <= s_keep;
                        r_full     <= w_sum[LOGN];
                        r_fill_ptr <= w_sum[LOGN-1:0];
                        // A packet ending mid-row needs one flush slot; ending on a row boundary does not.
                        if (s_last && (w_sum[LOGN-1:0] != {LOGN{1'b0}})) begin
                            r_state <= ST_FLUSH;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    r_flush    <= 1'b1;
                    r_fill_ptr <= {LOGN{1'b0}};
                    r_state    <= ST_RUN;
                    r_ready    <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = r_ready;
    assign din       = r_din;
    assign dst_in    = r_dst;
    assign in_vld    = r_vld;
    assign beat_full = r_full;
    assign flush     = r_flush;
    assign fill_ptr  = r_fill_ptr;

`ifdef PACK_DST_GEN_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_pkts;

    // Free-running wrap-around counters of accepted words and packets.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_words <= 32'd0;
            r_stat_pkts  <= 32'd0;
        end else if (w_accept) begin
            r_stat_words <= r_stat_words + {{(31-LOGN){1'b0}}, w_cnt};
            r_stat_pkts  <= r_stat_pkts + {31'd0, s_last};
        end else begin
            r_stat_words <= r_stat_words;
            r_stat_pkts  <= r_stat_pkts;
        end
    end

    assign stat_words = r_stat_words;
    assign stat_pkts  = r_stat_pkts;
`endif

endmodule

// File: tb/tb_pack_dst_gen.sv
// Self-checking bench for pack_dst_gen (N=4, DWIDTH=8): directed table, corner sequences,
// and random traffic against an arithmetic reference model.
module tb_pack_dst_gen;

    localparam int N      = 4;
    localparam int DWIDTH = 8;
    localparam int LOGN   = 2;

    logic                clk;
    logic                rstn;
    logic [N*DWIDTH-1:0] s_data;
    logic [N-1:0]        s_keep;
    logic                s_last;
    logic                s_valid;
    logic                s_ready;
    logic [N*DWIDTH-1:0] din;
    logic [N*LOGN-1:0]   dst_in;
    logic [N-1:0]        in_vld;
    logic                beat_full;
    logic                flush;
    logic [LOGN-1:0]     fill_ptr;
`ifdef PACK_DST_GEN_STATS_EN
    logic [31:0]         stat_words;
    logic [31:0]         stat_pkts;
`endif

    pack_dst_gen #(.N(N), .DWIDTH(DWIDTH), .LOGN(LOGN)) dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid),
        .s_ready(s_ready), .din(din), .dst_in(dst_in), .in_vld(in_vld),
        .beat_full(beat_full), .flush(flush), .fill_ptr(fill_ptr)
`ifdef PACK_DST_GEN_STATS_EN
        , .stat_words(stat_words), .stat_pkts(stat_pkts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int                  m_ptr;
    bit                  m_ready;
    bit                  m_pend;
    logic [N*DWIDTH-1:0] m_din;
    logic [N*LOGN-1:0]   m_dst;
    longint              m_words;
    longint              m_pkts;

    typedef struct packed {
        logic                v;
        logic [N-1:0]        k;
        logic [N*DWIDTH-1:0] d;
        logic                l;
        logic [N*DWIDTH-1:0] e_din;
        logic [N*LOGN-1:0]   e_dst;
        logic [N-1:0]        e_vld;
        logic                e_full;
        logic                e_flush;
        logic [LOGN-1:0]     e_ptr;
        logic                e_ready;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_ready = 1'b0;
        m_pend  = 1'b0;
        m_din   = '0;
        m_dst   = '0;
    endtask

    // One clock: predict from spec rules, drive, sample after the edge, compare.
    task automatic cycle(input bit v, input logic [N-1:0] k, input logic [N*DWIDTH-1:0] d, input bit l);
        int                  cnt;
        int                  tot;
        logic [LOGN-1:0]     lane_dst;
        logic [N-1:0]        e_vld;
        logic                e_full;
        logic                e_flush;
        logic                e_ready;
        logic [N*LOGN-1:0]   e_dst;
        logic [N*DWIDTH-1:0] e_din;
        int                  e_ptr;
        e_vld = '0; e_full = 1'b0; e_flush = 1'b0; e_ready = 1'b1;
        e_dst = m_dst; e_din = m_din; e_ptr = m_ptr;
        if (m_pend) begin
            e_flush = 1'b1;
            e_ptr   = 0;
            m_pend  = 1'b0;
        end else if (v && m_ready) begin
            cnt = 0;
            for (int i = 0; i < N; i++) begin
                lane_dst = LOGN'((m_ptr + cnt) % N);
                e_dst[i*LOGN +: LOGN] = lane_dst;
                if (k[i]) cnt++;
            end
            tot    = m_ptr + cnt;
            e_full = (tot >= N);
            e_ptr  = tot % N;
            e_vld  = k;
            e_din  = d;
            if (l && e_ptr != 0) begin
                m_pend  = 1'b1;
                e_ready = 1'b0;
            end
            m_words += cnt;
            m_pkts  += (l ? 1 : 0);
        end
        m_ptr = e_ptr; m_ready = e_ready; m_dst = e_dst; m_din = e_din;

        @(negedge clk);
        s_valid = v; s_keep = k; s_data = d; s_last = l;
        @(posedge clk);
        #1;
        chk("mdl_din",   64'(din),       64'(e_din));
        chk("mdl_dst",   64'(dst_in),    64'(e_dst));
        chk("mdl_vld",   64'(in_vld),    64'(e_vld));
        chk("mdl_full",  64'(beat_full), 64'(e_full));
        chk("mdl_flush", 64'(flush),     64'(e_flush));
        chk("mdl_ptr",   64'(fill_ptr),  64'(e_ptr));
        chk("mdl_ready", 64'(s_ready),   64'(e_ready));
    endtask

    initial begin
        m_words = 0;
        m_pkts  = 0;
        model_reset();
        rstn = 1'b0; s_valid = 1'b0; s_keep = '0; s_data = '0; s_last = 1'b0;

        //             v     k        d             l     din           dst    vld      full  flush ptr    ready
        tbl[0] = '{1'b0, 4'b0000, 32'h00000000, 1'b0, 32'h00000000, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[1] = '{1'b1, 4'b1111, 32'h44332211, 1'b0, 32'h44332211, 8'hE4, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[2] = '{1'b1, 4'b0011, 32'h88776655, 1'b0, 32'h88776655, 8'hA4, 4'b0011, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[3] = '{1'b1, 4'b1110, 32'hCCBBAA99, 1'b1, 32'hCCBBAA99, 8'h3A, 4'b1110, 1'b1, 1'b0, 2'd1, 1'b0};
        tbl[4] = '{1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'hCCBBAA99, 8'h3A, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1};
        tbl[5] = '{1'b1, 4'b0000, 32'h01020304, 1'b0, 32'h01020304, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[6] = '{1'b1, 4'b0011, 32'h0A0B0C0D, 1'b0, 32'h0A0B0C0D, 8'hA4, 4'b0011, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[7] = '{1'b1, 4'b0011, 32'h10203040, 1'b1, 32'h10203040, 8'h0E, 4'b0011, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[8] = '{1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h10203040, 8'h0E, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_din",   64'(din),       64'd0);
        chk("rst_dst",   64'(dst_in),    64'd0);
        chk("rst_vld",   64'(in_vld),    64'd0);
        chk("rst_flags", 64'({beat_full, flush}), 64'd0);
        chk("rst_ptr",   64'(fill_ptr),  64'd0);
        chk("rst_ready", 64'(s_ready),   64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].k, tbl[i].d, tbl[i].l);
            chk("tbl_din",   64'(din),       64'(tbl[i].e_din));
            chk("tbl_dst",   64'(dst_in),    64'(tbl[i].e_dst));
            chk("tbl_vld",   64'(in_vld),    64'(tbl[i].e_vld));
            chk("tbl_full",  64'(beat_full), 64'(tbl[i].e_full));
            chk("tbl_flush", 64'(flush),     64'(tbl[i].e_flush));
            chk("tbl_ptr",   64'(fill_ptr),  64'(tbl[i].e_ptr));
            chk("tbl_ready", 64'(s_ready),   64'(tbl[i].e_ready));
        end

        // Back-to-back packets with s_valid held high
        cycle(1'b1, 4'b0111, 32'hA1A2A3A4, 1'b1);
        chk("b2b_ptr3",  64'(fill_ptr), 64'd3);
        cycle(1'b1, 4'b1111, 32'hB1B2B3B4, 1'b0);
        chk("b2b_flush", 64'(flush),    64'd1);
        cycle(1'b1, 4'b0110, 32'hC1C2C3C4, 1'b0);
        chk("b2b_dst1",  64'(dst_in[3:2]), 64'd0);
        chk("b2b_dst2",  64'(dst_in[5:4]), 64'd1);
        chk("b2b_vld",   64'(in_vld),      64'(4'b0110));

        // Reset mid-packet with fill_ptr = 3
        cycle(1'b1, 4'b0001, 32'hD1D2D3D4, 1'b0);
        chk("mid_ptr3", 64'(fill_ptr), 64'd3);
        #3;
        rstn = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("mid_rst_out", 64'({din, dst_in, in_vld, beat_full, flush}), 64'd0);
        chk("mid_rst_ptr", 64'(fill_ptr), 64'd0);
        chk("mid_rst_rdy", 64'(s_ready),  64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        cycle(1'b0, 4'b0000, 32'h0, 1'b0);
        cycle(1'b1, 4'b0001, 32'hE1E2E3E4, 1'b0);
        chk("mid_after_dst0", 64'(dst_in[1:0]), 64'd0);

        // Random traffic against the reference model
        for (int t = 0; t < 400; t++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom), $urandom, ($urandom_range(0, 3) == 0));
        end
        cycle(1'b0, 4'b0000, 32'h0, 1'b0);

`ifdef PACK_DST_GEN_STATS_EN
        chk("stat_words", 64'(stat_words), 64'(m_words[31:0]));
        chk("stat_pkts",  64'(stat_pkts),  64'(m_pkts[31:0]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
